pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter TMO_W, default 8, width of the wait-state watchdog counter.
REQ-002 SHALL have parameter TIMEOUT, default 255, number of wait cycles before a forced release.
REQ-003 SHALL use one clock and an asynchronous active-low reset, listed first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-004 SHALL have the following data ports:
- load_use  input  1  load-use hazard detected in ID
- branch_taken  input  1  taken branch resolved in ID
- imem_req  input  1  fetch issued this cycle
- imem_ack  input  1  fetch data valid this cycle
- dmem_req  input  1  MEM-stage load/store active
- dmem_ack  input  1  data memory completes this cycle
- md_busy  input  1  multi-cycle mul/div in EX, not yet done
- hold_pc  output  1  freeze PC
- hold_if  output  1  freeze IF/ID register
- hold_id  output  1  freeze ID/EX register
- hold_ex  output  1  freeze EX/MEM register
- bubble_ex  output  1  zero control into ID/EX
- bubble_mem  output  1  zero control into EX/MEM
- bubble_wb  output  1  zero control into MEM/WB
- flush_if  output  1  clear IF/ID register
- err_timeout  output  1  sticky watchdog error
- stall_cnt  output  32  cycles with hold_pc asserted
- state  output  2  current FSM state

Function
REQ-005 SHALL implement FSM states RUN=0, DWAIT=1, MDWAIT=2, IWAIT=3.
REQ-006 In RUN, SHALL evaluate priority dmem miss (dmem_req & ~dmem_ack) > md_busy > imem miss (imem_req & ~imem_ack) > load_use > branch_taken.
REQ-007 Dmem miss in RUN SHALL enter DWAIT; outputs SHALL be combinational in that cycle: hold_pc, hold_if, hold_id, hold_ex, bubble_wb = 1.
REQ-008 md_busy in RUN SHALL enter MDWAIT; same cycle: hold_pc, hold_if, hold_id, bubble_mem = 1.
REQ-009 Imem miss in RUN SHALL enter IWAIT; same cycle: hold_pc, flush_if = 1; later stages advance.
REQ-010 load_use in RUN SHALL assert hold_pc, hold_if, bubble_ex for that cycle only; state stays RUN.
REQ-011 branch_taken in RUN SHALL assert flush_if, bubble_ex for that cycle only; state stays RUN.
REQ-012 In each wait state, the outputs of its entry condition SHALL stay asserted while the exit condition is false.
REQ-013 DWAIT SHALL exit to RUN on dmem_ack, MDWAIT on ~md_busy, IWAIT on imem_ack.
REQ-014 In the exit cycle, holds and bubbles SHALL deassert combinationally.
REQ-015 In the exit cycle, the RUN priority of REQ-006 SHALL be applied to the remaining inputs, so back-to-back events lose no cycle.
REQ-016 load_use and branch_taken SHALL be ignored outside RUN; they are level signals held by the frozen ID stage.
REQ-017 The watchdog SHALL clear on every state entry and increment each cycle in a wait state.
REQ-018 When the watchdog equals TIMEOUT, the FSM SHALL return to RUN, release all holds and set err_timeout.
REQ-019 err_timeout SHALL be cleared only by reset.
REQ-020 stall_cnt SHALL increment on every clock edge where hold_pc=1 and wrap from 0xFFFFFFFF to 0.
REQ-021 Unused state encodings SHALL return to RUN on the next edge.

Reset
REQ-022 While rst_n=0, state SHALL be RUN, and watchdog, stall_cnt and err_timeout SHALL be 0.
REQ-023 While rst_n=0, all hold, bubble and flush outputs SHALL be 0 regardless of inputs.
REQ-024 Reset asserted mid-wait SHALL abandon the wait immediately, with no pending event retained.

Structure
REQ-025 State encodings and the TIMEOUT default SHALL live in the shared pipeline package, pipe_pkg.
REQ-026 The watchdog SHALL be a sub-module, stall_wdog (clear, enable, terminal-count output).
REQ-027 This block SHALL consume the existing hazard detector's load-use and branch outputs; it SHALL NOT duplicate register-compare logic.

Verification
REQ-028 Dmem miss: dmem_req=1, dmem_ack=0 for 3 cycles then 1 -> holds high for 3 cycles, low in the ack cycle; stall_cnt=3; state 0->1->0.
REQ-029 Simultaneous: dmem miss, md_busy=1 and load_use=1 in the same cycle -> DWAIT first; after ack, MDWAIT until md_busy=0; load_use honoured only after returning to RUN.
REQ-030 Branch: branch_taken=1 in RUN -> flush_if=1 and bubble_ex=1 for exactly one cycle; hold_pc=0.
REQ-031 Timeout: TIMEOUT=4, dmem_ack never asserted -> forced RUN after 4 wait cycles; err_timeout stays 1 until rst_n=0.
REQ-032 Reset during MDWAIT: rst_n low for 1 cycle -> all outputs 0 immediately, state=0, stall_cnt=0.
REQ-033 Wrap: preload stall_cnt=0xFFFFFFFF via force, one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall FSM encodings, stage-control bundle and
// the RUN-state hazard priority used by the stall controller.
package pipe_pkg;

  localparam int unsigned StallTimeoutDefault = 255;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDwait  = 2'd1,
    StMdwait = 2'd2,
    StIwait  = 2'd3
  } stall_state_e;

  typedef struct packed {
    logic hold_pc;
    logic hold_if;
    logic hold_id;
    logic hold_ex;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
    logic flush_if;
  } stall_ctl_t;

  typedef struct packed {
    stall_state_e nxt;
    stall_ctl_t   ctl;
  } run_dec_t;

  // Stage controls held for as long as a wait state lasts.
  function automatic stall_ctl_t entry_ctl(stall_state_e s);
    stall_ctl_t c;
    c = '0;
    case (s)
      StDwait: begin
        c.hold_pc   = 1'b1;
        c.hold_if   = 1'b1;
        c.hold_id   = 1'b1;
        c.hold_ex   = 1'b1;
        c.bubble_wb = 1'b1;
      end
      StMdwait: begin
        c.hold_pc    = 1'b1;
        c.hold_if    = 1'b1;
        c.hold_id    = 1'b1;
        c.bubble_mem = 1'b1;
      end
      StIwait: begin
        c.hold_pc  = 1'b1;
        c.flush_if = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic run_dec_t run_priority(logic dmiss, logic md_busy, logic imiss,
                                            logic load_use, logic branch_taken);
    run_dec_t d;
    d.nxt = StRun;
    d.ctl = '0;
    if (dmiss) begin
      d.nxt = StDwait;
      d.ctl = entry_ctl(StDwait);
    end else if (md_busy) begin
      d.nxt = StMdwait;
      d.ctl = entry_ctl(StMdwait);
    end else if (imiss) begin
      d.nxt = StIwait;
      d.ctl = entry_ctl(StIwait);
    end else if (load_use) begin
      d.ctl.hold_pc   = 1'b1;
      d.ctl.hold_if   = 1'b1;
      d.ctl.bubble_ex = 1'b1;
    end else if (branch_taken) begin
      d.ctl.flush_if  = 1'b1;
      d.ctl.bubble_ex = 1'b1;
    end
    return d;
  endfunction

  function automatic logic wait_done(stall_state_e s, logic dmem_ack, logic md_busy,
                                     logic imem_ack);
    case (s)
      StDwait:  return dmem_ack;
      StMdwait: return ~md_busy;
      StIwait:  return imem_ack;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/stall_wdog.sv
// Wait-state watchdog: counts cycles while enabled, flags terminal count.
module stall_wdog #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TMO_W-1:0] TcVal = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: sequences memory and mul/div wait states,
// forwards single-cycle load-use and branch hazards, and counts stall cycles.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TIMEOUT = StallTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        imem_req,
  input  logic        imem_ack,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        md_busy,
  output logic        hold_pc,
  output logic        hold_if,
  output logic        hold_id,
  output logic        hold_ex,
  output logic        bubble_ex,
  output logic        bubble_mem,
  output logic        bubble_wb,
  output logic        flush_if,
  output logic        err_timeout,
  output logic [31:0] stall_cnt,
  output logic [1:0]  state
);

  stall_state_e state_q, state_d;
  stall_ctl_t   ctl, ctl_out;
  run_dec_t     dec;
  logic         dmiss, imiss;
  logic         wd_tc, wd_clear, wd_en;
  logic         exit_now, tmo_hit;
  logic         err_q;
  logic [31:0]  stall_cnt_q;

  assign dmiss = dmem_req & ~dmem_ack;
  assign imiss = imem_req & ~imem_ack;
  assign dec   = run_priority(dmiss, md_busy, imiss, load_use, branch_taken);

  // The exit cycle of a wait behaves as a RUN cycle so a queued event starts at once.
  always_comb begin
    state_d  = state_q;
    ctl      = '0;
    exit_now = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state_q)
      StRun: begin
        state_d = dec.nxt;
        ctl     = dec.ctl;
      end
      StDwait, StMdwait, StIwait: begin
        if (wd_tc) begin
          state_d = StRun;
          tmo_hit = 1'b1;
        end else if (wait_done(state_q, dmem_ack, md_busy, imem_ack)) begin
          exit_now = 1'b1;
          state_d  = dec.nxt;
          ctl      = dec.ctl;
        end else begin
          ctl = entry_ctl(state_q);
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign wd_clear = (state_d != state_q) | exit_now | tmo_hit;
  assign wd_en    = (state_q != StRun);

  stall_wdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .tc     (wd_tc)
  );

  // Stage controls are forced low for the whole time reset is held.
  assign ctl_out = rst_n ? ctl : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
      if (ctl_out.hold_pc) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign hold_pc     = ctl_out.hold_pc;
  assign hold_if     = ctl_out.hold_if;
  assign hold_id     = ctl_out.hold_id;
  assign hold_ex     = ctl_out.hold_ex;
  assign bubble_ex   = ctl_out.bubble_ex;
  assign bubble_mem  = ctl_out.bubble_mem;
  assign bubble_wb   = ctl_out.bubble_wb;
  assign flush_if    = ctl_out.flush_if;
  assign err_timeout = err_q;
  assign stall_cnt   = stall_cnt_q;
  assign state       = state_q;

endmodule
